fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the control unit. It owns the program counter and drives a synchronous instruction memory (1-cycle read latency). It presents each fetched instruction to decode, with opcode [6:0] and funct3 [14:12] split out for the control unit. It consumes the control unit's PCsrc and the branch target to redirect fetch, killing the wrong-path instruction already in flight.

Parameters:
- ADDR_WIDTH, 32, PC and memory address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  decode cannot accept; hold the current instruction.
- PCsrc  in  1  branch taken, from the control unit / branch compare.
- branch_target  in  ADDR_WIDTH  redirect address.
- imem_addr  out  ADDR_WIDTH  instruction memory address (= pc_f).
- imem_en  out  1  memory read enable. Memory holds rdata when en=0.
- imem_rdata  in  32  memory data, valid the cycle after an enabled read.
- instr  out  32  instruction to decode (NOP when invalid).
- opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- pc_out  out  ADDR_WIDTH  PC of instr.
- pc_plus4  out  ADDR_WIDTH  pc_out + 4.
- instr_valid  out  1  instr is a real, right-path instruction.
- fetch_fault  out  1  sticky misaligned-redirect flag.
- fetch_count  out  32  count of instructions accepted by decode.

Behaviour:
- Internal registers:
  - pc_f: next address to fetch.
  - req_pc, req_valid: the request whose data is on imem_rdata this cycle.
  - state: BOOT, RUN, HALT.
- Reset (rst=1 at a clk edge):
  - pc_f=RESET_PC, req_pc=0, req_valid=0, state=BOOT, fetch_fault=0, fetch_count=0.
  - Outputs after reset: instr_valid=0, instr=NOP (32'h0000_0013), pc_out=0.
  - A reset asserted mid-operation discards any in-flight request; no instr_valid in the cycle following reset.
- Combinational outputs:
  - imem_addr=pc_f.
  - imem_en = (state!=HALT) && !stall.
  - instr_valid = req_valid.
  - instr = req_valid ? imem_rdata : NOP. opcode and funct3 are derived from instr.
  - pc_out=req_pc; pc_plus4=req_pc+4, wrapping modulo 2^ADDR_WIDTH.
- Accept condition: accept = instr_valid && !stall. fetch_count increments on accept and wraps at 2^32.
- BOOT:
  - One cycle; issues the read of RESET_PC.
  - If !stall, go to RUN with req_pc<=pc_f, req_valid<=1, pc_f<=pc_f+4.
  - If stall, remain in BOOT.
- RUN, with stall=1:
  - pc_f, req_pc, req_valid and state all hold; no memory read is issued.
  - Outputs are unchanged. The memory holds rdata, so no skid register is needed.
  - PCsrc is ignored while stall=1.
- RUN, with stall=0 and accepted redirect (PCsrc && instr_valid):
  - If branch_target[1:0]==0: pc_f<=branch_target, req_valid<=0, giving exactly one bubble; the wrong-path read of pc_f is killed.
  - If branch_target[1:0]!=0: fetch_fault<=1, state<=HALT, req_valid<=0, pc_f<=branch_target.
- RUN, with stall=0 and no redirect: req_pc<=pc_f, req_valid<=1, pc_f<=pc_f+4.
- PCsrc while instr_valid=0 is ignored (bubbles cannot branch).
- HALT:
  - imem_en=0, instr_valid=0; imem_addr shows the faulting target.
  - HALT is left only by rst.
- pc_f+4 wraps modulo 2^ADDR_WIDTH with no fault.

Decomposition:
- Shared package rv_pkg holds:
  - NOP_INSTR constant.
  - fetch_state_t enum {BOOT, RUN, HALT}.
  - Opcode constants (ADDI 7'b0010011, BNE 7'b1100011), shared with the control unit.
- One sub-module, pc_register: holds pc_f, with load (redirect), enable (!stall) and a RESET_PC reset value.

Test Plan:
- Reset release, stall=0, RESET_PC=0, memory word0=32'h00500093 (addi x1,x0,5):
  - Cycle after BOOT: instr_valid=1, pc_out=0, opcode=7'b0010011, funct3=0, pc_plus4=4.
  - Next cycle: pc_out=4.
- Stall held for 3 cycles while pc_out=8:
  - imem_en=0; instr, pc_out=8 and instr_valid stay stable.
  - fetch_count does not change during the stall.
  - After release: pc_out=12 on the next cycle.
- PCsrc=1, branch_target=32'h40 while pc_out=8:
  - Next cycle instr_valid=0, instr=NOP.
  - Following cycle pc_out=32'h40.
  - PC 12 is never presented valid.
- PCsrc=1 with stall=1: no redirect, state unchanged. PCsrc=1 while instr_valid=0: ignored.
- PCsrc=1, branch_target=32'h42:
  - fetch_fault=1, instr_valid=0, imem_en=0 from then on.
  - Stays halted until rst; after rst, fetch_fault=0 and fetch restarts at RESET_PC.
- rst asserted mid-run at pc_out=32'h20: next cycle instr_valid=0 and state BOOT, then pc_out=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32 front-end definitions used by the fetch unit and the control unit.
package rv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  OPC_ADDI  = 7'b0010011;
  localparam logic [6:0]  OPC_BNE   = 7'b1100011;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Instruction addresses must be word aligned; the low two bits flag a bad target.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_pc_register.sv
// Fetch program counter: redirect load has priority over sequential advance.
module pc_register
  import rv_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  output logic [ADDR_WIDTH-1:0] pc_q
);

  logic [ADDR_WIDTH-1:0] pc_d;

  // Next PC selection; the +4 wraps naturally at the address width.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_addr;
    end else if (en) begin
      pc_d = pc_q + ADDR_WIDTH'(32'd4);
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle synchronous imem and
// presents fetched instructions to decode, squashing wrong-path fetches on redirect.
module fetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  PCsrc,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_en,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instr,
  output logic [6:0]            opcode,
  output logic [2:0]            funct3,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic                  instr_valid,
  output logic                  fetch_fault,
  output logic [31:0]           fetch_count
);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  req_valid_q, req_valid_d;
  logic                  fault_q, fault_d;
  logic [31:0]           count_q, count_d;
  logic [ADDR_WIDTH-1:0] pc_f;
  logic                  accept;
  logic                  redirect;
  logic                  pc_advance;

  pc_register #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .RESET_PC  (RESET_PC)
  ) u_pc_register (
    .clk      (clk),
    .rst      (rst),
    .en       (pc_advance),
    .load     (redirect),
    .load_addr(branch_target),
    .pc_q     (pc_f)
  );

  // Bubbles cannot branch, and a stalled decode cannot redirect.
  always_comb begin
    accept     = req_valid_q && !stall;
    redirect   = (state_q == RUN) && !stall && PCsrc && req_valid_q;
    pc_advance = !stall && ((state_q == BOOT) || ((state_q == RUN) && !redirect));
  end

  // Fetch sequencing: in-flight request tracking, fault latch and accept counter.
  always_comb begin
    state_d     = state_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    fault_d     = fault_q;
    count_d     = accept ? (count_q + 32'd1) : count_q;
    case (state_q)
      BOOT: begin
        if (!stall) begin
          state_d     = RUN;
          req_pc_d    = pc_f;
          req_valid_d = 1'b1;
        end else begin
          state_d = BOOT;
        end
      end
      RUN: begin
        if (stall) begin
          state_d = RUN;
        end else if (redirect) begin
          // The read issued this cycle is wrong-path; drop it.
          req_valid_d = 1'b0;
          if (is_misaligned(branch_target[1:0])) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            state_d = RUN;
          end
        end else begin
          req_pc_d    = pc_f;
          req_valid_d = 1'b1;
        end
      end
      HALT: begin
        req_valid_d = 1'b0;
      end
      default: begin
        state_d     = BOOT;
        req_valid_d = 1'b0;
      end
    endcase
  end

  // Stage state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      req_pc_q    <= {ADDR_WIDTH{1'b0}};
      req_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      count_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      fault_q     <= fault_d;
      count_q     <= count_d;
    end
  end

  // Decode-facing view; the memory holds rdata while disabled, so stalls need no skid buffer.
  always_comb begin
    imem_addr   = pc_f;
    imem_en     = (state_q != HALT) && !stall;
    instr_valid = req_valid_q;
    instr       = req_valid_q ? imem_rdata : NOP_INSTR;
    opcode      = instr[6:0];
    funct3      = instr[14:12];
    pc_out      = req_pc_q;
    pc_plus4    = req_pc_q + ADDR_WIDTH'(32'd4);
    fetch_fault = fault_q;
    fetch_count = count_q;
  end

endmodule
